// File: rtl/dvi_pkg.sv
// ---------------------------------------------------------------------------
// dvi_pkg
//   Shared definitions for the DVI receive path: the four TMDS control-token
//   code words, the word-alignment state enum and the helper functions that
//   classify and decode aligned 10-bit TMDS words.
//
//   Contents:
//     CTRL_TOKEN_00..11   10-bit control-token code words (bit 0 sent first)
//     align_state_e       ST_SEARCH / ST_VERIFY / ST_LOCKED
//     is_ctrl_token()     1 when a word is one of the four control tokens
//     ctrl_token_value()  2-bit {c1,c0} carried by a control token
//     tmds_decode_data()  8-bit pixel byte carried by a data word
//     next_offset()       bit offset advanced modulo 10
// ---------------------------------------------------------------------------
package dvi_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } align_state_e;

  function automatic logic is_ctrl_token(input logic [9:0] q);
    return (q == CTRL_TOKEN_00) || (q == CTRL_TOKEN_01) ||
           (q == CTRL_TOKEN_10) || (q == CTRL_TOKEN_11);
  endfunction

  // Only meaningful when is_ctrl_token(q) is true; other words return 00.
  function automatic logic [1:0] ctrl_token_value(input logic [9:0] q);
    logic [1:0] v;
    case (q)
      CTRL_TOKEN_01: v = 2'b01;
      CTRL_TOKEN_10: v = 2'b10;
      CTRL_TOKEN_11: v = 2'b11;
      default:       v = 2'b00;
    endcase
    return v;
  endfunction

  // q[9] marks an inverted payload; q[8] selects XOR (1) or XNOR (0)
  // chaining between neighbouring bits of the transition-minimised byte.
  function automatic logic [7:0] tmds_decode_data(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] dec;
    d      = q[9] ? ~q[7:0] : q[7:0];
    dec    = '0;
    dec[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return dec;
  endfunction

  function automatic logic [3:0] next_offset(input logic [3:0] o);
    return (o >= 4'd9) ? 4'd0 : o + 4'd1;
  endfunction

endpackage

// File: rtl/tmds_word_align.sv
// ---------------------------------------------------------------------------
// tmds_word_align
//   Recovers 10-bit word alignment of a TMDS channel from control-token runs
//   seen during blanking. The previous raw word is kept so that a 20-bit
//   window {tmds_word, prev} can be sliced at any bit offset 0..9; the slice
//   and its token flag form pipeline stage 1. The alignment FSM steps on the
//   registered (stage-1) token flag.
//
//   Ports:
//     pix_clk       in   pixel clock, rising edge
//     rst           in   asynchronous active-high reset
//     tmds_word     in   raw deserialized word, bit 0 received first
//     win_word      out  stage-1 aligned word
//     win_is_token  out  stage-1 flag: win_word is a control token
//     lock_next     out  FSM will be LOCKED after the coming edge
//     locked        out  FSM is LOCKED
//     offset        out  current bit offset 0..9
// ---------------------------------------------------------------------------
module tmds_word_align
  import dvi_pkg::*;
#(
  parameter int LOCK_RUN     = 8,
  parameter int SEARCH_DWELL = 2048,
  parameter int LOSS_TIMEOUT = 4096
) (
  input  logic       pix_clk,
  input  logic       rst,
  input  logic [9:0] tmds_word,
  output logic [9:0] win_word,
  output logic       win_is_token,
  output logic       lock_next,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int DWELL_W = $clog2(SEARCH_DWELL + 1);
  localparam int RUN_W   = $clog2(LOCK_RUN + 1);
  localparam int LOSS_W  = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SEARCH_DWELL - 1);
  localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(LOCK_RUN - 1);
  localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_TIMEOUT - 1);

  align_state_e       state_q, state_d;
  logic [9:0]         prev_q, prev_d;
  logic [9:0]         win_q, win_d;
  logic               tok_q, tok_d;
  logic [3:0]         offset_q, offset_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic [19:0]        cat;

  // Window select: the older word sits in the low half because bit 0 is the
  // first bit on the wire, so a slice starting at 'offset' is one contiguous
  // stretch of the serial stream.
  always_comb begin
    prev_d = tmds_word;
    cat    = {tmds_word, prev_q};
    win_d  = 10'(cat >> offset_q);
    tok_d  = is_ctrl_token(win_d);
  end

  // Alignment FSM. It looks at the stage-1 flag, so the word captured on the
  // same edge as an offset change was still sliced at the old offset; that
  // single stale word is accepted rather than inserting a bubble.
  // A token seen in SEARCH wins over a simultaneous dwell expiry.
  // All counters stop at their terminal value and never wrap.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    dwell_d  = dwell_q;
    run_d    = run_q;
    loss_d   = loss_q;
    case (state_q)
      ST_SEARCH: begin
        if (tok_q) begin
          run_d   = RUN_W'(1);
          loss_d  = '0;
          state_d = (LOCK_RUN <= 1) ? ST_LOCKED : ST_VERIFY;
        end else if (dwell_q >= DWELL_LAST) begin
          offset_d = next_offset(offset_q);
          dwell_d  = '0;
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      ST_VERIFY: begin
        if (tok_q) begin
          if (run_q >= RUN_LAST) begin
            state_d = ST_LOCKED;
            loss_d  = '0;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end else begin
          state_d  = ST_SEARCH;
          offset_d = next_offset(offset_q);
          dwell_d  = '0;
          run_d    = '0;
        end
      end
      ST_LOCKED: begin
        if (tok_q) begin
          loss_d = '0;
        end else if (loss_q >= LOSS_LAST) begin
          state_d = ST_SEARCH;
          dwell_d = '0;
          loss_d  = '0;
          run_d   = '0;
        end else begin
          loss_d = loss_q + LOSS_W'(1);
        end
      end
      default: begin
        state_d  = ST_SEARCH;
        offset_d = '0;
        dwell_d  = '0;
        run_d    = '0;
        loss_d   = '0;
      end
    endcase
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_SEARCH;
      prev_q   <= '0;
      win_q    <= '0;
      tok_q    <= 1'b0;
      offset_q <= '0;
      dwell_q  <= '0;
      run_q    <= '0;
      loss_q   <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      win_q    <= win_d;
      tok_q    <= tok_d;
      offset_q <= offset_d;
      dwell_q  <= dwell_d;
      run_q    <= run_d;
      loss_q   <= loss_d;
    end
  end

  // lock_next lets the decode stage register the lock-completing token with
  // valid ctrl on the same edge that 'locked' rises.
  assign win_word     = win_q;
  assign win_is_token = tok_q;
  assign lock_next    = (state_d == ST_LOCKED);
  assign locked       = (state_q == ST_LOCKED);
  assign offset       = offset_q;

endmodule

// File: rtl/tmds_decoder.sv
// ---------------------------------------------------------------------------
// tmds_decoder
//   Single-channel TMDS receive decoder. tmds_word_align finds the word
//   boundary and provides the stage-1 aligned word; this module adds stage 2,
//   which turns that word into either a control value or a pixel byte.
//   A window is on the outputs two cycles after it is formed. At offset 0
//   the window is the previous raw word.
//
//   Ports:
//     pix_clk    in   pixel clock, rising edge
//     rst        in   asynchronous active-high reset
//     tmds_word  in   raw deserialized word, bit 0 received first
//     de         out  decoded word is pixel data
//     ctrl       out  last decoded control value {c1,c0}
//     data       out  decoded pixel byte, 0 when de=0
//     locked     out  word alignment lock
//     offset     out  current bit offset 0..9
// ---------------------------------------------------------------------------
module tmds_decoder
  import dvi_pkg::*;
#(
  parameter int LOCK_RUN     = 8,
  parameter int SEARCH_DWELL = 2048,
  parameter int LOSS_TIMEOUT = 4096
) (
  input  logic       pix_clk,
  input  logic       rst,
  input  logic [9:0] tmds_word,
  output logic       de,
  output logic [1:0] ctrl,
  output logic [7:0] data,
  output logic       locked,
  output logic [3:0] offset
);

  logic [9:0] win_word;
  logic       win_is_token;
  logic       lock_next;

  logic       de_q, de_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic [7:0] data_q, data_d;

  tmds_word_align #(
    .LOCK_RUN    (LOCK_RUN),
    .SEARCH_DWELL(SEARCH_DWELL),
    .LOSS_TIMEOUT(LOSS_TIMEOUT)
  ) u_align (
    .pix_clk     (pix_clk),
    .rst         (rst),
    .tmds_word   (tmds_word),
    .win_word    (win_word),
    .win_is_token(win_is_token),
    .lock_next   (lock_next),
    .locked      (locked),
    .offset      (offset)
  );

  // Stage 2 decode. Unlocked output is forced quiet. While locked, a data
  // word leaves ctrl at the value of the most recent token so the timing
  // sink sees stable sync levels across active video.
  always_comb begin
    de_d   = 1'b0;
    ctrl_d = 2'b00;
    data_d = 8'h00;
    if (lock_next) begin
      if (win_is_token) begin
        ctrl_d = ctrl_token_value(win_word);
      end else begin
        de_d   = 1'b1;
        ctrl_d = ctrl_q;
        data_d = tmds_decode_data(win_word);
      end
    end
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      de_q   <= 1'b0;
      ctrl_q <= 2'b00;
      data_q <= 8'h00;
    end else begin
      de_q   <= de_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign de   = de_q;
  assign ctrl = ctrl_q;
  assign data = data_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// ---------------------------------------------------------------------------
// tb_tmds_decoder
//   Scoreboard bench for tmds_decoder with shortened dwell/timeout values.
//   The driver feeds a serial bit queue (so any bit shift can be produced),
//   steps a cycle-level reference model and queues the expected outputs; a
//   monitor pops one expectation per clock and compares.
// ---------------------------------------------------------------------------
module tb_tmds_decoder;

  localparam int LR = 8;
  localparam int SD = 16;
  localparam int LT = 32;

  localparam int M_SEARCH = 0;
  localparam int M_VERIFY = 1;
  localparam int M_LOCKED = 2;

  logic       pix_clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] tmds_word = '0;
  logic       de;
  logic [1:0] ctrl;
  logic [7:0] data;
  logic       locked;
  logic [3:0] offset;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  bit          bq[$];
  logic [9:0]  tok_tab[4] = '{10'b1101010100, 10'b0010101011,
                              10'b0101010100, 10'b1010101011};

  // Reference model state
  logic [9:0] m_prev = '0;
  logic [9:0] m_win = '0;
  logic       m_tok = 1'b0;
  int         m_state = M_SEARCH;
  int         m_offset = 0;
  int         m_dwell = 0;
  int         m_run = 0;
  int         m_loss = 0;
  logic       m_de = 1'b0;
  logic [1:0] m_ctrl = 2'b00;
  logic [7:0] m_data = 8'h00;

  always #5 pix_clk = ~pix_clk;

  tmds_decoder #(
    .LOCK_RUN    (LR),
    .SEARCH_DWELL(SD),
    .LOSS_TIMEOUT(LT)
  ) dut (
    .pix_clk  (pix_clk),
    .rst      (rst),
    .tmds_word(tmds_word),
    .de       (de),
    .ctrl     (ctrl),
    .data     (data),
    .locked   (locked),
    .offset   (offset)
  );

  function automatic int tokenIndex(input logic [9:0] w);
    for (int i = 0; i < 4; i++) begin
      if (w == tok_tab[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] refDecode(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] r;
    d = q[7:0];
    if (q[9]) d = ~d;
    r = '0;
    r[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      r[i] = q[8] ? (d[i] ^ d[i-1]) : !(d[i] ^ d[i-1]);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One rising edge of the reference model; returns the expected outputs
  // after that edge as {locked, offset, de, ctrl, data}.
  task automatic modelStep(input logic [9:0] w, input logic r, output logic [15:0] e);
    logic [9:0] nw;
    int ns, no, nd, nr, nl, p;
    if (r) begin
      m_prev = '0; m_win = '0; m_tok = 1'b0;
      m_state = M_SEARCH; m_offset = 0; m_dwell = 0; m_run = 0; m_loss = 0;
      m_de = 1'b0; m_ctrl = 2'b00; m_data = 8'h00;
    end else begin
      for (int b = 0; b < 10; b++) begin
        p = m_offset + b;
        nw[b] = (p < 10) ? m_prev[p] : w[p-10];
      end
      ns = m_state; no = m_offset; nd = m_dwell; nr = m_run; nl = m_loss;
      if (m_state == M_SEARCH) begin
        if (m_tok) begin
          nr = 1;
          ns = (LR <= 1) ? M_LOCKED : M_VERIFY;
          nl = 0;
        end else if (m_dwell == SD - 1) begin
          no = (m_offset + 1) % 10;
          nd = 0;
        end else begin
          nd = m_dwell + 1;
        end
      end else if (m_state == M_VERIFY) begin
        if (m_tok) begin
          nr = m_run + 1;
          if (nr >= LR) begin
            ns = M_LOCKED;
            nl = 0;
          end
        end else begin
          ns = M_SEARCH; no = (m_offset + 1) % 10; nd = 0; nr = 0;
        end
      end else begin
        if (m_tok) nl = 0;
        else if (m_loss == LT - 1) begin
          ns = M_SEARCH; nd = 0; nl = 0; nr = 0;
        end else nl = m_loss + 1;
      end
      if (ns == M_LOCKED) begin
        if (m_tok) begin
          m_de = 1'b0; m_data = 8'h00; m_ctrl = 2'(tokenIndex(m_win));
        end else begin
          m_de = 1'b1; m_data = refDecode(m_win);
        end
      end else begin
        m_de = 1'b0; m_ctrl = 2'b00; m_data = 8'h00;
      end
      m_state = ns; m_offset = no; m_dwell = nd; m_run = nr; m_loss = nl;
      m_prev = w;
      m_win  = nw;
      m_tok  = (tokenIndex(nw) >= 0);
    end
    e = {(m_state == M_LOCKED), 4'(m_offset), m_de, m_ctrl, m_data};
  endtask

  // Called at a falling edge; drives one word for the next rising edge and
  // returns at the following falling edge.
  task automatic applyStimulus(input logic [9:0] word, input logic r);
    logic [15:0] e;
    if (r && !rst) begin
      rst = 1'b1;
      #1;
      checkOutput("async_reset_outputs", 32'({locked, offset, de, ctrl, data}), 32'h0);
    end else begin
      rst = r;
    end
    tmds_word = word;
    modelStep(word, r, e);
    exp_q.push_back(e);
    @(negedge pix_clk);
  endtask

  // Serialises a symbol into the bit queue and sends one raw word.
  task automatic sendSymbol(input logic [9:0] sym);
    logic [9:0] w;
    for (int b = 0; b < 10; b++) bq.push_back(sym[b]);
    for (int b = 0; b < 10; b++) w[b] = bq.pop_front();
    applyStimulus(w, 1'b0);
  endtask

  task automatic resetDut(input int n);
    bq.delete();
    repeat (n) applyStimulus(10'h000, 1'b1);
  endtask

  task automatic sendRandomTraffic(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 0) sendSymbol(tok_tab[$urandom_range(0, 3)]);
      else sendSymbol(10'($urandom));
    end
  endtask

  // Monitor: one expected output per clock
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge pix_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("scoreboard{lock,off,de,ctrl,data}",
                    32'({locked, offset, de, ctrl, data}), 32'(e));
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    bit done;

    @(negedge pix_clk);
    resetDut(3);
    checkOutput("reset_state", 32'({locked, offset, de, ctrl, data}), 32'h0);

    $display("[TB] aligned token stream at offset 0");
    repeat (LR + 3) sendSymbol(tok_tab[0]);
    checkOutput("off0_locked", 32'(locked), 32'd1);
    checkOutput("off0_offset", 32'(offset), 32'd0);
    checkOutput("off0_de", 32'(de), 32'd0);
    checkOutput("off0_ctrl", 32'(ctrl), 32'd0);

    $display("[TB] data decode after lock");
    sendSymbol(tok_tab[3]);
    sendSymbol(10'h100);
    sendSymbol(10'h200);
    sendSymbol(tok_tab[0]);
    checkOutput("data100_de", 32'(de), 32'd1);
    checkOutput("data100_data", 32'(data), 32'h00);
    checkOutput("data100_ctrl_held", 32'(ctrl), 32'd3);
    sendSymbol(tok_tab[0]);
    checkOutput("data200_de", 32'(de), 32'd1);
    checkOutput("data200_data", 32'(data), 32'hFF);
    checkOutput("data200_ctrl_held", 32'(ctrl), 32'd3);

    $display("[TB] random locked traffic");
    sendRandomTraffic(80);
    repeat (3) sendSymbol(tok_tab[1]);
    checkOutput("random_still_locked", 32'(locked), 32'd1);

    $display("[TB] loss of lock");
    cnt = 0;
    done = 0;
    while (!done && cnt < LT + 8) begin
      sendSymbol(10'h100);
      cnt++;
      if (!locked) done = 1;
    end
    checkOutput("loss_seen", 32'(done), 32'd1);
    checkOutput("loss_cycle_window", 32'((cnt >= LT - 2) && (cnt <= LT + 2)), 32'd1);
    checkOutput("loss_de", 32'(de), 32'd0);
    checkOutput("loss_data", 32'(data), 32'h00);
    checkOutput("loss_offset_kept", 32'(offset), 32'd0);

    $display("[TB] verify break");
    repeat (5) sendSymbol(tok_tab[0]);
    sendSymbol(10'h100);
    sendSymbol(tok_tab[0]);
    sendSymbol(tok_tab[0]);
    checkOutput("break_offset", 32'(offset), 32'd1);
    checkOutput("break_unlocked", 32'(locked), 32'd0);
    cnt = 0;
    done = 0;
    while (!done && cnt < 12 * SD) begin
      sendSymbol(tok_tab[0]);
      cnt++;
      if (locked) done = 1;
    end
    checkOutput("relock_seen", 32'(done), 32'd1);
    checkOutput("relock_offset", 32'(offset), 32'd0);
    checkOutput("no_early_relock", 32'(cnt >= 8 * SD), 32'd1);

    $display("[TB] alignment at offset 7");
    resetDut(2);
    repeat (7) bq.push_back(1'b0);
    cnt = 0;
    done = 0;
    while (!done && cnt < 7 * SD + LR + 3) begin
      sendSymbol(tok_tab[2]);
      cnt++;
      if (locked) done = 1;
    end
    checkOutput("off7_locked", 32'(done), 32'd1);
    checkOutput("off7_offset", 32'(offset), 32'd7);
    checkOutput("off7_ctrl", 32'(ctrl), 32'd2);
    checkOutput("off7_de", 32'(de), 32'd0);
    sendRandomTraffic(30);
    repeat (2) sendSymbol(tok_tab[2]);
    sendSymbol(10'h155);
    sendSymbol(10'h2AA);
    checkOutput("locked_before_reset", 32'(locked), 32'd1);

    $display("[TB] reset while locked");
    resetDut(2);
    repeat (LR + 3) sendSymbol(tok_tab[1]);
    checkOutput("after_reset_locked", 32'(locked), 32'd1);
    checkOutput("after_reset_offset", 32'(offset), 32'd0);
    checkOutput("after_reset_ctrl", 32'(ctrl), 32'd1);

    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
